// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcode constants, the
// instruction-cycle phase encoding and the control-strobe bundle.
package cpu_pkg;

  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  // Opcodes whose result comes from the ALU and is written back to the accumulator.
  function automatic logic is_aluop(input logic [2:0] op);
    case (op)
      ADD, AND, XOR, LDA: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Instruction-sequencing controller: an 8-phase counter with a halted state,
// and combinational decode of the control strobes from phase, opcode and zero.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int NPHASE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  localparam logic [2:0] LAST_PHASE = 3'(NPHASE - 1);

  phase_e phase_reg;
  logic   halted_reg;
  ctrl_t  ctrl;

  logic op_hlt;
  logic op_skz;
  logic op_sto;
  logic op_jmp;
  logic op_alu;

  // Decoding through a case with a zero default keeps an unknown opcode from
  // raising any qualified strobe.
  always_comb begin
    op_hlt = 1'b0;
    op_skz = 1'b0;
    op_sto = 1'b0;
    op_jmp = 1'b0;
    case (opcode)
      HLT:     op_hlt = 1'b1;
      SKZ:     op_skz = 1'b1;
      STO:     op_sto = 1'b1;
      JMP:     op_jmp = 1'b1;
      default: ;
    endcase
    op_alu = is_aluop(opcode);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
    end else if (!halted_reg) begin
      if (phase_reg == OP_ADDR && op_hlt) begin
        halted_reg <= 1'b1;
      end else if (phase_reg == LAST_PHASE) begin
        phase_reg <= INST_ADDR;
      end else begin
        phase_reg <= phase_e'(phase_reg + 3'd1);
      end
    end
  end

  always_comb begin
    ctrl = '0;
    if (halted_reg) begin
      ctrl.halt = 1'b1;
    end else begin
      case (phase_reg)
        INST_ADDR: begin
          ctrl.sel = 1'b1;
        end
        INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = op_hlt;
        end
        OP_FETCH: begin
          ctrl.rd = op_alu;
        end
        ALU_OP: begin
          ctrl.rd     = op_alu;
          ctrl.inc_pc = op_skz && zero;
          ctrl.ld_pc  = op_jmp;
          ctrl.data_e = op_sto;
        end
        STORE: begin
          ctrl.rd     = op_alu;
          ctrl.ld_ac  = op_alu;
          ctrl.ld_pc  = op_jmp;
          ctrl.wr     = op_sto;
          ctrl.data_e = op_sto;
        end
        default: ;
      endcase
    end
  end

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign ld_ir  = ctrl.ld_ir;
  assign inc_pc = ctrl.inc_pc;
  assign halt   = ctrl.halt;
  assign ld_pc  = ctrl.ld_pc;
  assign data_e = ctrl.data_e;
  assign ld_ac  = ctrl.ld_ac;
  assign wr     = ctrl.wr;
  assign phase  = phase_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: an independent phase/halt model feeds
// a scoreboard of expected phase and strobes, compared once per clock.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;

  cpu_controller #(.NPHASE(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic [8:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [2:0] m_phase;
  logic       m_halted;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] observed();
    return {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};
  endfunction

  // Bit order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  function automatic logic [8:0] model_ctrl(input logic [2:0] ph, input logic [2:0] op,
                                            input logic z, input logic hlt);
    logic alu, sto, jmp, skz, ish;
    logic s, r, li, ip, h, lp, de, la, w;
    alu = (op === 3'b010) || (op === 3'b011) || (op === 3'b100) || (op === 3'b101);
    sto = (op === 3'b110);
    jmp = (op === 3'b111);
    skz = (op === 3'b001);
    ish = (op === 3'b000);
    {s, r, li, ip, h, lp, de, la, w} = 9'b0;
    if (hlt) begin
      h = 1'b1;
    end else begin
      s  = (ph <= 3'd3);
      r  = (ph >= 3'd1 && ph <= 3'd3) || (ph >= 3'd5 && alu);
      li = (ph == 3'd2) || (ph == 3'd3);
      ip = (ph == 3'd4) || (ph == 3'd6 && skz && (z === 1'b1));
      h  = (ph == 3'd4) && ish;
      lp = (ph >= 3'd6) && jmp;
      de = (ph >= 3'd6) && sto;
      la = (ph == 3'd7) && alu;
      w  = (ph == 3'd7) && sto;
    end
    return {s, r, li, ip, h, lp, de, la, w};
  endfunction

  // Entered and left at a falling edge: drive, score, compare, then model the edge.
  task automatic run_cycle(input logic [2:0] op, input logic z);
    exp_t e, got_e;
    opcode = op;
    zero   = z;
    #1;
    e.ph   = m_phase;
    e.ctrl = model_ctrl(m_phase, op, z, m_halted);
    sb.push_back(e);
    got_e = sb.pop_front();
    $display("cyc %0d phase %0d op %b zero %b ctrl %b exp %b", cyc, phase, opcode, zero,
             observed(), got_e.ctrl);
    check_eq("phase", 32'(phase), 32'(got_e.ph));
    check_eq("strobes", 32'(observed()), 32'(got_e.ctrl));
    check_eq("no_x", 32'($isunknown({observed(), phase})), 32'd0);
    check_eq("rd_wr_excl", 32'(rd & wr), 32'd0);
    check_eq("pc_excl", 32'(ld_pc & inc_pc), 32'd0);
    @(posedge clk);
    if (!m_halted) begin
      if (m_phase == 3'd4 && op === 3'b000) m_halted = 1'b1;
      else m_phase = m_phase + 3'd1;
    end
    @(negedge clk);
    cyc++;
  endtask

  // One full instruction from INST_ADDR; opcode is random in phases 0-3 and
  // zero is random except in phase 6 (and forced in phase 5 when asked).
  task automatic run_instr(input logic [2:0] op, input logic z6, input bit force5,
                           input logic z5);
    for (int p = 0; p < 8; p++) begin
      logic [2:0] o;
      logic       z;
      o = (p < 4) ? 3'($urandom_range(0, 7)) : op;
      z = 1'($urandom_range(0, 1));
      if (p == 6) z = z6;
      if (p == 5 && force5) z = z5;
      run_cycle(o, z);
    end
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_phase", 32'(phase), 32'd0);
    check_eq("rst_strobes", 32'(observed()), 32'h100);
    @(negedge clk);
    rst      = 1'b0;
    m_phase  = 3'd0;
    m_halted = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    opcode   = 3'b010;
    zero     = 1'b0;
    m_phase  = 3'd0;
    m_halted = 1'b0;
    @(negedge clk);
    check_eq("reset_phase", 32'(phase), 32'd0);
    check_eq("reset_strobes", 32'(observed()), 32'h100);
    @(negedge clk);
    rst = 1'b0;

    // Advance into OP_FETCH, then reset between edges.
    for (int i = 0; i < 5; i++) run_cycle(3'b010, 1'b0);
    check_eq("pre_reset_phase", 32'(phase), 32'd5);
    reset_pulse();

    // Count 0..7 and wrap back to 0.
    for (int i = 0; i < 9; i++) run_cycle(3'b010, 1'b0);
    check_eq("wrap_phase", 32'(phase), 32'd1);
    for (int i = 0; i < 7; i++) run_cycle(3'b010, 1'b0);

    run_instr(3'b010, 1'b0, 1'b0, 1'b0); // ADD
    run_instr(3'b110, 1'b1, 1'b0, 1'b0); // STO
    run_instr(3'b001, 1'b1, 1'b0, 1'b0); // SKZ taken
    run_instr(3'b001, 1'b0, 1'b1, 1'b1); // SKZ not taken, zero toggled in phase 5
    run_instr(3'b111, 1'b1, 1'b0, 1'b0); // JMP
    run_instr(3'b101, 1'b1, 1'b0, 1'b0); // LDA
    run_instr(3'b011, 1'b0, 1'b0, 1'b0); // AND
    run_instr(3'b100, 1'b1, 1'b0, 1'b0); // XOR
    run_instr(3'bxxx, 1'b1, 1'b0, 1'b0); // unknown opcode in phases 4-7

    // HLT: park in phase 4 for 20 clocks while opcode wanders.
    for (int p = 0; p < 5; p++) run_cycle((p < 4) ? 3'b011 : 3'b000, 1'b0);
    check_eq("halted_phase", 32'(phase), 32'd4);
    for (int i = 0; i < 20; i++) run_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    check_eq("halt_hold_phase", 32'(phase), 32'd4);
    check_eq("halt_hold_strobes", 32'(observed()), 32'h010);
    reset_pulse();
    check_eq("post_halt_halt", 32'(halt), 32'd0);
    run_instr(3'b010, 1'b0, 1'b0, 1'b0);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
